// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core control logic: register-zero constant,
// mult/div sequencer state encoding and counter width.
package mips_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         MD_CNT_W = 6;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_sequencer.sv
// Mult/div occupancy tracker: goes busy for MD_CYCLES cycles after each start
// and reports busy so dependent HI/LO readers and further mult/div can wait.
module md_sequencer
  import mips_pkg::*;
#(
  parameter int MD_CYCLES = 8
) (
  input  logic CLK,
  input  logic Reset,
  input  logic MD_Start,
  output logic MD_Busy
);

  localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_CYCLES);

  md_state_e           state_q;
  logic [MD_CNT_W-1:0] count_q;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= MD_IDLE;
      count_q <= '0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          count_q <= '0;
          if (MD_Start) begin
            state_q <= MD_BUSY;
            count_q <= MD_LOAD;
          end
        end
        MD_BUSY: begin
          // Final busy cycle is the one showing count==1.
          if (count_q == MD_CNT_W'(1)) begin
            state_q <= MD_IDLE;
            count_q <= '0;
          end else begin
            count_q <= count_q - MD_CNT_W'(1);
          end
        end
        default: begin
          state_q <= MD_IDLE;
          count_q <= '0;
        end
      endcase
    end
  end

  assign MD_Busy = (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_control_unit.sv
// ID-stage hazard controller: load-use and HI/LO interlocks, branch squash,
// mult/div issue and a saturating stall-cycle counter.
module hazard_control_unit
  import mips_pkg::*;
#(
  parameter int MD_CYCLES   = 8,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   CLK,
  input  logic                   Reset,
  input  logic [4:0]             ID_Rs,
  input  logic [4:0]             ID_Rt,
  input  logic                   ID_UsesRs,
  input  logic                   ID_UsesRt,
  input  logic                   ID_IsMD,
  input  logic                   ID_ReadsHiLo,
  input  logic                   EX_MemRead,
  input  logic [4:0]             EX_Rw,
  input  logic                   EX_RegWrite,
  input  logic                   EX_BranchTaken,
  output logic                   PC_Write,
  output logic                   IFID_Write,
  output logic                   IFID_Flush,
  output logic                   IDEX_Bubble,
  output logic                   MD_Start,
  output logic                   MD_Busy,
  output logic [STALL_CNT_W-1:0] StallCycles
);

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (v == '1) ? v : v + STALL_CNT_W'(1);
  endfunction

  logic load_use;
  logic md_haz;
  logic stall;
  logic [STALL_CNT_W-1:0] stall_q;
  logic [STALL_CNT_W-1:0] stall_d;

  md_sequencer #(
    .MD_CYCLES (MD_CYCLES)
  ) u_md_seq (
    .CLK      (CLK),
    .Reset    (Reset),
    .MD_Start (MD_Start),
    .MD_Busy  (MD_Busy)
  );

  assign load_use = EX_MemRead && EX_RegWrite && (EX_Rw != REG_ZERO) &&
                    ((ID_UsesRs && (ID_Rs == EX_Rw)) || (ID_UsesRt && (ID_Rt == EX_Rw)));
  assign md_haz   = MD_Busy && (ID_IsMD || ID_ReadsHiLo);

  // Taken branch beats every stall: the ID instruction is wrong-path anyway.
  always_comb begin
    PC_Write    = 1'b1;
    IFID_Write  = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Bubble = 1'b0;
    MD_Start    = 1'b0;
    stall       = 1'b0;
    if (EX_BranchTaken) begin
      IFID_Flush  = 1'b1;
      IDEX_Bubble = 1'b1;
    end else if (load_use || md_haz) begin
      PC_Write    = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Bubble = 1'b1;
      stall       = 1'b1;
    end else begin
      MD_Start    = ID_IsMD;
    end
  end

  assign stall_d = stall ? sat_inc(stall_q) : stall_q;

  always_ff @(posedge CLK) begin
    if (Reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign StallCycles = stall_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: a cycle-level reference model
// queues expected outputs; a negedge monitor pops and compares them.
module tb_hazard_control_unit;

  localparam int MD_CYCLES   = 8;
  localparam int STALL_CNT_W = 4;
  localparam int SAT         = (1 << STALL_CNT_W) - 1;

  logic                   CLK = 1'b0;
  logic                   Reset;
  logic [4:0]             ID_Rs, ID_Rt, EX_Rw;
  logic                   ID_UsesRs, ID_UsesRt, ID_IsMD, ID_ReadsHiLo;
  logic                   EX_MemRead, EX_RegWrite, EX_BranchTaken;
  logic                   PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, MD_Start, MD_Busy;
  logic [STALL_CNT_W-1:0] StallCycles;

  hazard_control_unit #(
    .MD_CYCLES   (MD_CYCLES),
    .STALL_CNT_W (STALL_CNT_W)
  ) dut (
    .CLK            (CLK),
    .Reset          (Reset),
    .ID_Rs          (ID_Rs),
    .ID_Rt          (ID_Rt),
    .ID_UsesRs      (ID_UsesRs),
    .ID_UsesRt      (ID_UsesRt),
    .ID_IsMD        (ID_IsMD),
    .ID_ReadsHiLo   (ID_ReadsHiLo),
    .EX_MemRead     (EX_MemRead),
    .EX_Rw          (EX_Rw),
    .EX_RegWrite    (EX_RegWrite),
    .EX_BranchTaken (EX_BranchTaken),
    .PC_Write       (PC_Write),
    .IFID_Write     (IFID_Write),
    .IFID_Flush     (IFID_Flush),
    .IDEX_Bubble    (IDEX_Bubble),
    .MD_Start       (MD_Start),
    .MD_Busy        (MD_Busy),
    .StallCycles    (StallCycles)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic                   pc;
    logic                   ifid_w;
    logic                   flush;
    logic                   bubble;
    logic                   start;
    logic                   busy;
    logic [STALL_CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   md_rem = 0;   // remaining busy cycles of the in-flight mult/div
  int   cnt_m  = 0;   // reference stall counter
  string tag = "init";

  // One clock cycle: apply inputs, queue the expected outputs, advance the model.
  task automatic drive(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic ismd, input logic hilo,
                       input logic mr, input logic [4:0] rw, input logic rwr, input logic br);
    exp_t e;
    bit   busy, lu, stl;
    int   nrem, ncnt;
    Reset = rst; ID_Rs = rs; ID_Rt = rt; ID_UsesRs = urs; ID_UsesRt = urt;
    ID_IsMD = ismd; ID_ReadsHiLo = hilo; EX_MemRead = mr; EX_Rw = rw;
    EX_RegWrite = rwr; EX_BranchTaken = br;
    busy = (md_rem > 0);
    lu   = mr && rwr && (rw != 0) && ((urs && rs == rw) || (urt && rt == rw));
    stl  = 1'b0;
    if (br) begin
      e.pc = 1; e.ifid_w = 1; e.flush = 1; e.bubble = 1; e.start = 0;
    end else if (lu || (busy && (ismd || hilo))) begin
      e.pc = 0; e.ifid_w = 0; e.flush = 0; e.bubble = 1; e.start = 0;
      stl = 1'b1;
    end else begin
      e.pc = 1; e.ifid_w = 1; e.flush = 0; e.bubble = 0; e.start = ismd;
    end
    e.busy = busy;
    e.cnt  = STALL_CNT_W'(cnt_m);
    exp_q.push_back(e);
    if (rst) begin
      nrem = 0; ncnt = 0;
    end else begin
      nrem = e.start ? MD_CYCLES : (md_rem > 0 ? md_rem - 1 : 0);
      ncnt = stl ? ((cnt_m + 1 > SAT) ? SAT : cnt_m + 1) : cnt_m;
    end
    @(posedge CLK);
    #1;
    md_rem = nrem;
    cnt_m  = ncnt;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: outputs are valid every driven cycle; compare mid-cycle.
  initial begin : monitor
    exp_t e, a;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, MD_Start, MD_Busy, StallCycles};
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL %s t=%0t pc/ifw/fl/bub/st/busy/cnt got %b%b%b%b%b%b/%0d expected %b%b%b%b%b%b/%0d",
                   tag, $time, a.pc, a.ifid_w, a.flush, a.bubble, a.start, a.busy, a.cnt,
                   e.pc, e.ifid_w, e.flush, e.bubble, e.start, e.busy, e.cnt);
        end
      end
    end
  end

  initial begin : stim
    Reset = 1; ID_Rs = 0; ID_Rt = 0; ID_UsesRs = 0; ID_UsesRt = 0; ID_IsMD = 0;
    ID_ReadsHiLo = 0; EX_MemRead = 0; EX_Rw = 0; EX_RegWrite = 0; EX_BranchTaken = 0;
    repeat (2) @(posedge CLK);
    #1;
    md_rem = 0; cnt_m = 0;

    tag = "reset_idle";     idle(2);
    tag = "load_use_rs";    drive(0, 1, 2, 1, 1, 0, 0, 1, 1, 1, 0); idle(1);
    tag = "load_use_rt";    drive(0, 3, 5, 1, 1, 0, 0, 1, 5, 1, 0); idle(1);
    tag = "rw_zero";        drive(0, 0, 0, 1, 1, 0, 0, 1, 0, 1, 0); idle(1);
    tag = "unused_rs";      drive(0, 4, 0, 0, 0, 0, 0, 1, 4, 1, 0); idle(1);
    tag = "mult_issue";     drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tag = "mfhi_interlock"; for (int i = 0; i < MD_CYCLES + 1; i++) drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    idle(1);
    tag = "lu_plus_branch"; drive(0, 1, 0, 1, 0, 0, 0, 1, 1, 1, 1); idle(1);
    tag = "md_in_flush";    drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1); idle(1);
    tag = "mult_then_both"; drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    drive(0, 2, 0, 1, 0, 1, 0, 1, 2, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    tag = "reset_mid_busy"; drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); idle(2);
    tag = "saturate";       for (int i = 0; i < SAT + 6; i++) drive(0, 7, 0, 1, 0, 0, 0, 1, 7, 1, 0);
    idle(1);
    tag = "random";
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 63) == 0),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0));
    end
    idle(2);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge CLK);
    if (exp_q.size() > 0) begin
      fails++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    @(posedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
